ram_rd_check: RTL and testbench

//  Read-back checker downstream of the single-port RAM and its read/write driver.

---
 rtl/ram_rd_check.sv | 198 +++++++++++++++++++
 tb/tb_ram_rd_check.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_check.sv
// Read-back checker that snoops a single-port RAM, shadows every written word and compares each returned word.
// Optional first-mismatch data logging (err_exp/err_act) is enabled by defining RAM_CHK_LOG_EN.
module ram_rd_check #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int PASS_CNT = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ram_wr_en,
  input  logic          ram_rd_en,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_wr_data,
  input  logic [DW-1:0] ram_rd_data,
  output logic [15:0]   chk_cnt,
  output logic [15:0]   err_cnt,
  output logic          err_flag,
  output logic          proto_err,
  output logic          pass,
  output logic [AW-1:0] err_addr
`ifdef RAM_CHK_LOG_EN
  ,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_act
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [15:0] PASS_TGT = 16'(PASS_CNT);
  localparam logic [15:0] SAT      = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  logic [DW-1:0]    shadow_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic             pv_q [RD_LAT];
  logic [DW-1:0]    pe_q [RD_LAT];
  logic [AW-1:0]    pa_q [RD_LAT];

  logic             rd_issue;
  logic             cmp_v, mismatch;
  logic [DW-1:0]    cmp_e;
  logic [AW-1:0]    cmp_a;

  state_t           state_q, state_d;
  logic [15:0]      chk_q, chk_d, err_q, err_d, good_q, good_d;
  logic             flag_q, flag_d, proto_q, proto_d;
  logic [AW-1:0]    eaddr_q, eaddr_d;
`ifdef RAM_CHK_LOG_EN
  logic [DW-1:0]    eexp_q, eexp_d, eact_q, eact_d;
`endif

  // A simultaneous write+read is a protocol error: the write lands, the read is dropped.
  assign rd_issue = ram_rd_en & ~ram_wr_en;

  // Shadow data needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (ram_wr_en) shadow_q[ram_addr] <= ram_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            valid_q <= '0;
    else if (clr)       valid_q <= '0;
    else if (ram_wr_en) valid_q[ram_addr] <= 1'b1;
  end

  // Expected word is frozen at issue time and travels alongside the read.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    logic          v_in;
    logic [DW-1:0] e_in;
    logic [AW-1:0] a_in;
    if (gi == 0) begin : g_head
      assign v_in = rd_issue & valid_q[ram_addr];
      assign e_in = shadow_q[ram_addr];
      assign a_in = ram_addr;
    end else begin : g_tail
      assign v_in = pv_q[gi-1];
      assign e_in = pe_q[gi-1];
      assign a_in = pa_q[gi-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv_q[gi] <= 1'b0;
        pe_q[gi] <= '0;
        pa_q[gi] <= '0;
      end else if (clr) begin
        pv_q[gi] <= 1'b0;
      end else begin
        pv_q[gi] <= v_in;
        pe_q[gi] <= e_in;
        pa_q[gi] <= a_in;
      end
    end
  end

  assign cmp_v    = pv_q[RD_LAT-1];
  assign cmp_e    = pe_q[RD_LAT-1];
  assign cmp_a    = pa_q[RD_LAT-1];
  assign mismatch = cmp_v & (ram_rd_data != cmp_e);

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    err_d   = err_q;
    good_d  = good_q;
    flag_d  = flag_q;
    proto_d = proto_q;
    eaddr_d = eaddr_q;
`ifdef RAM_CHK_LOG_EN
    eexp_d  = eexp_q;
    eact_d  = eact_q;
`endif
    if (cmp_v) begin
      if (chk_q != SAT) chk_d = chk_q + 16'd1;
      if (mismatch) begin
        if (err_q != SAT) err_d = err_q + 16'd1;
        good_d = '0;
        flag_d = 1'b1;
        if (!flag_q) begin
          eaddr_d = cmp_a;
`ifdef RAM_CHK_LOG_EN
          eexp_d  = cmp_e;
          eact_d  = ram_rd_data;
`endif
        end
      end else if (good_q != SAT) begin
        good_d = good_q + 16'd1;
      end
    end
    if (ram_wr_en && ram_rd_en) proto_d = 1'b1;

    case (state_q)
      S_IDLE:  if (ram_wr_en) state_d = S_RUN;
      S_RUN:   if (mismatch) state_d = S_FAIL;
               else if (good_d >= PASS_TGT) state_d = S_PASS;
      S_PASS:  if (mismatch) state_d = S_FAIL;
      default: state_d = S_FAIL;
    endcase

    // Clear wins over a compare completing in the same cycle.
    if (clr) begin
      state_d = S_IDLE;
      chk_d   = '0;
      err_d   = '0;
      good_d  = '0;
      flag_d  = 1'b0;
      proto_d = 1'b0;
      eaddr_d = '0;
`ifdef RAM_CHK_LOG_EN
      eexp_d  = '0;
      eact_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      chk_q   <= '0;
      err_q   <= '0;
      good_q  <= '0;
      flag_q  <= 1'b0;
      proto_q <= 1'b0;
      eaddr_q <= '0;
`ifdef RAM_CHK_LOG_EN
      eexp_q  <= '0;
      eact_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      good_q  <= good_d;
      flag_q  <= flag_d;
      proto_q <= proto_d;
      eaddr_q <= eaddr_d;
`ifdef RAM_CHK_LOG_EN
      eexp_q  <= eexp_d;
      eact_q  <= eact_d;
`endif
    end
  end

  assign chk_cnt   = chk_q;
  assign err_cnt   = err_q;
  assign err_flag  = flag_q;
  assign proto_err = proto_q;
  assign pass      = (state_q == S_PASS);
  assign err_addr  = eaddr_q;
`ifdef RAM_CHK_LOG_EN
  assign err_exp   = eexp_q;
  assign err_act   = eact_q;
`endif

endmodule

// File: tb/tb_ram_rd_check.sv
// Scoreboard bench for ram_rd_check: one instance with RD_LAT=1 and one with RD_LAT=2 share stimulus.
module tb_ram_rd_check;

  logic       clk = 1'b0;
  logic       rst, clr, wr_en, rd_en, corrupt;
  logic [4:0] addr;
  logic [7:0] wdata;

  logic [15:0] chk_o [2];
  logic [15:0] err_o [2];
  logic        flag_o [2];
  logic        proto_o [2];
  logic        pass_o [2];
  logic [4:0]  eaddr_o [2];
`ifdef RAM_CHK_LOG_EN
  logic [7:0]  eexp_o [2];
  logic [7:0]  eact_o [2];
`endif

  always #5 clk = ~clk;

  // Behavioural RAM: registered read with 1 and 2 cycle taps.
  logic [7:0] ram_mem [32];
  logic [7:0] p1_d, p2_d;
  logic       p1_v, p2_v;

  always @(posedge clk) if (wr_en) ram_mem[addr] <= wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
    end else begin
      p1_v <= rd_en & ~wr_en;
      p1_d <= corrupt ? 8'hFF : ram_mem[addr];
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end

  ram_rd_check #(.AW(5), .DW(8), .RD_LAT(1), .PASS_CNT(32)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .ram_wr_en(wr_en), .ram_rd_en(rd_en),
    .ram_addr(addr), .ram_wr_data(wdata), .ram_rd_data(p1_d),
    .chk_cnt(chk_o[0]), .err_cnt(err_o[0]), .err_flag(flag_o[0]),
    .proto_err(proto_o[0]), .pass(pass_o[0]), .err_addr(eaddr_o[0])
`ifdef RAM_CHK_LOG_EN
    , .err_exp(eexp_o[0]), .err_act(eact_o[0])
`endif
  );

  ram_rd_check #(.AW(5), .DW(8), .RD_LAT(2), .PASS_CNT(32)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .ram_wr_en(wr_en), .ram_rd_en(rd_en),
    .ram_addr(addr), .ram_wr_data(wdata), .ram_rd_data(p2_d),
    .chk_cnt(chk_o[1]), .err_cnt(err_o[1]), .err_flag(flag_o[1]),
    .proto_err(proto_o[1]), .pass(pass_o[1]), .err_addr(eaddr_o[1])
`ifdef RAM_CHK_LOG_EN
    , .err_exp(eexp_o[1]), .err_act(eact_o[1])
`endif
  );

  typedef struct {
    int          tag;
    logic [15:0] chk;
    logic [15:0] err;
    logic        flag;
    logic        pss;
    logic [4:0]  eaddr;
    logic [7:0]  eexp;
    logic [7:0]  eact;
  } rec_t;

  rec_t q_a[$];
  rec_t q_b[$];

  int total = 0;
  int bad   = 0;

  // Reference model of what the checker should report.
  logic [7:0]  m_mem [32];
  bit          m_vld [32];
  logic [15:0] m_chk, m_err;
  logic        m_flag;
  logic [4:0]  m_eaddr;
  logic [7:0]  m_eexp, m_eact;
  int          m_state;  // 0 idle, 1 run, 2 pass, 3 fail
  int          m_good;
  int          tag_n = 0;

  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", name, inst, act, exp);
    end
  endtask

  task automatic check_rec(input int inst, input rec_t r);
    $display("rd#%0d dut%0d chk=%0d err=%0d flag=%0b pass=%0b", r.tag, inst, chk_o[inst], err_o[inst], flag_o[inst], pass_o[inst]);
    cmp("sb_chk", inst, 32'(chk_o[inst]), 32'(r.chk));
    cmp("sb_err", inst, 32'(err_o[inst]), 32'(r.err));
    cmp("sb_flag", inst, 32'(flag_o[inst]), 32'(r.flag));
    cmp("sb_pass", inst, 32'(pass_o[inst]), 32'(r.pss));
    cmp("sb_eaddr", inst, 32'(eaddr_o[inst]), 32'(r.eaddr));
`ifdef RAM_CHK_LOG_EN
    cmp("sb_eexp", inst, 32'(eexp_o[inst]), 32'(r.eexp));
    cmp("sb_eact", inst, 32'(eact_o[inst]), 32'(r.eact));
`endif
  endtask

  // Monitors: a compare completes on the edge where the RAM presents read data.
  always @(posedge clk) begin
    if (p1_v) begin
      #1;
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty dut0: got response want none");
      end else check_rec(0, q_a.pop_front());
    end
  end

  always @(posedge clk) begin
    if (p2_v) begin
      #1;
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty dut1: got response want none");
      end else check_rec(1, q_b.pop_front());
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    m_chk = '0; m_err = '0; m_flag = 1'b0; m_eaddr = '0;
    m_eexp = '0; m_eact = '0; m_state = 0; m_good = 0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d; corrupt = 1'b0;
    m_mem[a] = d; m_vld[a] = 1'b1;
    if (m_state == 0) m_state = 1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic bad_data);
    rec_t       r;
    logic [7:0] act;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; addr = a; corrupt = bad_data;
    if (m_vld[a]) begin
      act = bad_data ? 8'hFF : m_mem[a];
      if (m_chk != 16'hFFFF) m_chk++;
      if (act != m_mem[a]) begin
        if (m_err != 16'hFFFF) m_err++;
        if (!m_flag) begin
          m_eaddr = a; m_eexp = m_mem[a]; m_eact = act;
        end
        m_flag = 1'b1; m_good = 0;
        if (m_state != 0) m_state = 3;
      end else begin
        m_good++;
        if (m_state == 1 && m_good >= 32) m_state = 2;
      end
    end
    r.tag = tag_n++; r.chk = m_chk; r.err = m_err; r.flag = m_flag;
    r.pss = (m_state == 2); r.eaddr = m_eaddr; r.eexp = m_eexp; r.eact = m_eact;
    q_a.push_back(r);
    q_b.push_back(r);
  endtask

  task automatic idle_wait();
    int n;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; corrupt = 1'b0;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
      q_a.delete(); q_b.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic expect_all(input string name, input int inst, input int c, input int e,
                            input int f, input int p, input int pr, input int ea);
    $display("%s dut%0d chk=%0d err=%0d flag=%0b pass=%0b proto=%0b eaddr=%0d", name, inst,
             chk_o[inst], err_o[inst], flag_o[inst], pass_o[inst], proto_o[inst], eaddr_o[inst]);
    cmp({name, "_chk"}, inst, 32'(chk_o[inst]), c);
    cmp({name, "_err"}, inst, 32'(err_o[inst]), e);
    cmp({name, "_flag"}, inst, 32'(flag_o[inst]), f);
    cmp({name, "_pass"}, inst, 32'(pass_o[inst]), p);
    cmp({name, "_proto"}, inst, 32'(proto_o[inst]), pr);
    cmp({name, "_eaddr"}, inst, 32'(eaddr_o[inst]), ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; corrupt = 1'b0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) expect_all("reset", k, 0, 0, 0, 0, 0, 0);

    // Read of a never-written address is not compared.
    do_read(5'd3, 1'b0);
    idle_wait();
    for (int k = 0; k < 2; k++) expect_all("unwritten", k, 0, 0, 0, 0, 0, 0);

    // Full sweep, all matching.
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) do_read(5'(i), 1'b0);
    idle_wait();
    for (int k = 0; k < 2; k++) expect_all("sweep", k, 32, 0, 0, 1, 0, 0);

    // Rewrite while the read is in flight; frozen expected must still match.
    do_write(5'd7, 8'hA5);
    do_read(5'd7, 1'b0);
    do_write(5'd7, 8'h3C);
    idle_wait();
    for (int k = 0; k < 2; k++) expect_all("inflight_wr", k, 33, 0, 0, 1, 0, 0);

    // Sweep with a corrupted word at address 5.
    do_clr();
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) do_read(5'(i), i == 5);
    idle_wait();
    for (int k = 0; k < 2; k++) begin
      expect_all("corrupt", k, 32, 1, 1, 0, 0, 5);
`ifdef RAM_CHK_LOG_EN
      cmp("corrupt_eexp", k, 32'(eexp_o[k]), 32'h05);
      cmp("corrupt_eact", k, 32'(eact_o[k]), 32'hFF);
`endif
    end

    // Write and read together.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd2; wdata = 8'h11;
    m_mem[2] = 8'h11; m_vld[2] = 1'b1;
    idle_wait();
    for (int k = 0; k < 2; k++) expect_all("proto", k, 32, 1, 1, 0, 1, 5);
    do_clr();
    for (int k = 0; k < 2; k++) expect_all("clr", k, 0, 0, 0, 0, 0, 0);

    // Async reset with reads in flight.
    do_write(5'd0, 8'h00);
    do_write(5'd1, 8'h01);
    do_read(5'd0, 1'b0);
    do_read(5'd1, 1'b0);
    @(negedge clk);
    rd_en = 1'b0; rst = 1'b1;
    q_a.delete(); q_b.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) expect_all("rst_flight", k, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) do_read(5'(i), 1'b0);
    idle_wait();
    for (int k = 0; k < 2; k++) expect_all("resweep", k, 32, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
